// File: rtl/microsequencer_pkg.sv
// ============================================================================
// Module      : microsequencer_pkg
// Description : Shared control-unit definitions: microaddress width, N-mode
//               and condition-select encodings, default fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package microsequencer_pkg;

    localparam int UADDR_W = 10;

    typedef logic [UADDR_W-1:0] uaddr_t;

    typedef enum logic [2:0] {
        NS_ENCODE = 3'd0,
        NS_INCR   = 3'd1,
        NS_JUMP   = 3'd2,
        NS_BRANCH = 3'd3,
        NS_WAIT   = 3'd4,
        NS_CALL   = 3'd5,
        NS_RET    = 3'd6,
        NS_FETCH  = 3'd7
    } ns_mode_e;

    typedef enum logic [1:0] {
        CS_MOC       = 2'd0,
        CS_COND_TRUE = 2'd1,
        CS_IRQ       = 2'd2,
        CS_ONE       = 2'd3
    } cond_sel_e;

    localparam uaddr_t FETCH_STATE_DEFAULT = 10'd1;

endpackage

`default_nettype wire

// File: rtl/micro_return_stack.sv
// ============================================================================
// Module      : micro_return_stack
// Description : LIFO of microsubroutine return addresses with push, pop,
//               flush and full/empty status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module micro_return_stack
    import microsequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   flush_i,
    input  uaddr_t push_data_i,
    output uaddr_t top_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    logic [SPW-1:0]                          sp_q;
    logic [SPW-1:0]                          sp_d;
    logic [AW-1:0]                           w_wr_idx;
    logic [AW-1:0]                           w_top_idx;
    logic                                    w_do_push;
    logic                                    w_do_pop;
    logic [STACK_DEPTH-1:0][UADDR_W-1:0]     w_entries;

    assign full_o    = (sp_q == SP_FULL);
    assign empty_o   = (sp_q == '0);
    assign w_wr_idx  = sp_q[AW-1:0];
    // Depth is a power of two, so the empty case simply wraps to a don't-care entry.
    assign w_top_idx = AW'(sp_q - SPW'(1));
    assign top_o     = w_entries[w_top_idx];

    assign w_do_push = push_i && !full_o && !flush_i;
    assign w_do_pop  = pop_i && !empty_o && !flush_i && !push_i;

    always_comb begin
        sp_d = sp_q;
        if (flush_i) begin
            sp_d = '0;
        end else if (w_do_push) begin
            sp_d = sp_q + SPW'(1);
        end else if (w_do_pop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    generate
        for (genvar i = 0; i < STACK_DEPTH; i++) begin : g_entry
            uaddr_t entry_q;

            always_ff @(posedge clk) begin
                if (reset_n && w_do_push && (w_wr_idx == AW'(i))) begin
                    entry_q <= push_data_i;
                end
            end

            assign w_entries[i] = entry_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/microsequencer.sv
// ============================================================================
// Module      : microsequencer
// Description : Next-state address unit of the microprogrammed control unit:
//               condition mux, next-address mux, incrementer, hold register,
//               micro-return stack and sticky stack error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int     STACK_DEPTH = 4,
    parameter uaddr_t FETCH_STATE = FETCH_STATE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         N,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic [UADDR_W-1:0] cr,
    input  logic [UADDR_W-1:0] enc_state,
    input  logic               moc,
    input  logic               cond_true,
    input  logic               irq,
    output logic [UADDR_W-1:0] current_state,
    output logic               stack_ovf,
    output logic               stack_udf
);

    uaddr_t incr_q;
    uaddr_t hold_q;
    logic   stack_ovf_q;
    logic   stack_ovf_d;
    logic   stack_udf_q;
    logic   stack_udf_d;

    logic   w_sel_cond;
    logic   w_c;
    uaddr_t w_next;
    logic   w_push;
    logic   w_pop;
    logic   w_flush;
    uaddr_t w_stack_top;
    logic   w_stack_full;
    logic   w_stack_empty;

    always_comb begin
        w_sel_cond = 1'b1;
        case (cond_sel_e'(cond_sel))
            CS_MOC:       w_sel_cond = moc;
            CS_COND_TRUE: w_sel_cond = cond_true;
            CS_IRQ:       w_sel_cond = irq;
            CS_ONE:       w_sel_cond = 1'b1;
            default:      w_sel_cond = 1'b1;
        endcase
        w_c = w_sel_cond ^ inv;
    end

    always_comb begin
        w_next      = incr_q;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        stack_ovf_d = stack_ovf_q;
        stack_udf_d = stack_udf_q;

        case (ns_mode_e'(N))
            NS_ENCODE: w_next = enc_state;
            NS_INCR:   w_next = incr_q;
            NS_JUMP:   w_next = cr;
            NS_BRANCH: w_next = w_c ? cr : incr_q;
            NS_WAIT:   w_next = w_c ? cr : hold_q;
            NS_CALL: begin
                w_next = cr;
                if (w_stack_full) begin
                    stack_ovf_d = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            NS_RET: begin
                if (w_stack_empty) begin
                    stack_udf_d = 1'b1;
                    w_next      = FETCH_STATE;
                end else begin
                    w_pop  = 1'b1;
                    w_next = w_stack_top;
                end
            end
            NS_FETCH: begin
                w_next  = FETCH_STATE;
                w_flush = 1'b1;
            end
            default: w_next = incr_q;
        endcase

        // Reset forces address 0 and suppresses any stack traffic this cycle.
        if (!reset_n) begin
            w_next  = '0;
            w_push  = 1'b0;
            w_pop   = 1'b0;
            w_flush = 1'b0;
        end
    end

    assign current_state = w_next;
    assign stack_ovf     = stack_ovf_q;
    assign stack_udf     = stack_udf_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            incr_q      <= 10'd1;
            hold_q      <= '0;
            stack_ovf_q <= 1'b0;
            stack_udf_q <= 1'b0;
        end else begin
            incr_q      <= w_next + 10'd1;
            hold_q      <= w_next;
            stack_ovf_q <= stack_ovf_d;
            stack_udf_q <= stack_udf_d;
        end
    end

    micro_return_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .push_data_i (incr_q),
        .top_o       (w_stack_top),
        .full_o      (w_stack_full),
        .empty_o     (w_stack_empty)
    );

endmodule

`default_nettype wire
